// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: ex/CSR bundle layout, load-type bits, drop limit.
// No logic beyond a saturating drop-counter helper; no latency or backpressure of its own.
package mem_stage_pkg;

  // Exception/CSR bundle as handed down the pipe, MSB first.
  typedef struct packed {
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [13:0] csr_num;
    logic        ertn;
    logic        has_int;
    logic        adef;
    logic        sys;
    logic        brk;
    logic        ine;
    logic        ale;
  } ex_zip_t;

  localparam int EX_ZIP_W   = $bits(ex_zip_t);
  localparam int EX_FLAGS_W = 7;  // ertn..ale occupy the low bits

  localparam int LD_INST_W = 5;
  localparam int LD_W  = 0;
  localparam int LD_HU = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_B  = 4;

  localparam int DROP_MAX = 2;

  // Fields latched from execute, excluding the parameterised ex bundle.
  typedef struct packed {
    logic [31:0]          pc;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          result;
    logic                 res_from_mem;
    logic [LD_INST_W-1:0] ld_inst;
    logic                 csr_re;
  } ms_inst_t;

  function automatic logic [1:0] drop_next(input logic [1:0] cnt, input logic [1:0] inc,
                                           input logic dec);
    logic [2:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc} - {2'b00, dec};
    return (sum > 3'(DROP_MAX)) ? 2'(DROP_MAX) : sum[1:0];
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects and sign/zero-extends the addressed byte/halfword of a load word.
// Purely combinational: zero latency, no backpressure.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]          rdata,
  input  logic [1:0]           offset,
  input  logic [LD_INST_W-1:0] ld_inst,
  output logic [31:0]          load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    if (ld_inst[LD_B])
      load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_inst[LD_BU])
      load_data = {24'd0, byte_sel};
    else if (ld_inst[LD_H])
      load_data = {{16{half_sel[15]}}, half_sel};
    else if (ld_inst[LD_HU])
      load_data = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction, waits for its data_ok, extracts load data; drops responses of flushed requests.
// Latency: 1 cycle for non-memory ops, until data_ok for loads; stalls upstream via ms_allowin, buffers data when ws_allowin is low.
module mem_stage #(
  parameter int EX_ZIP_W = mem_stage_pkg::EX_ZIP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_to_ms_valid,
  output logic                ms_allowin,
  input  logic [31:0]         es_pc,
  input  logic                es_rf_we,
  input  logic [4:0]          es_rf_waddr,
  input  logic [31:0]         es_result,
  input  logic                es_res_from_mem,
  input  logic [4:0]          es_ld_inst,
  input  logic                es_csr_re,
  input  logic [EX_ZIP_W-1:0] es_ex_zip,
  input  logic                es_mem_issued,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [31:0]         ms_pc,
  output logic                ms_rf_we,
  output logic [4:0]          ms_rf_waddr,
  output logic [31:0]         ms_final_result,
  output logic                ms_csr_re,
  output logic [EX_ZIP_W-1:0] ms_ex_zip,
  output logic                ms_data_pending,
  output logic                ms_ex,
  input  logic                wb_ex
);
  import mem_stage_pkg::*;

  ms_inst_t            es_inst;
  ms_inst_t            ms_inst;
  logic [EX_ZIP_W-1:0] ms_ex_zip_r;
  logic                ms_valid;
  logic                ms_wait;
  logic                buf_valid;
  logic [31:0]         data_buf;
  logic [1:0]          drop_cnt;

  logic        data_ok_for_me;
  logic        ms_ready_go;
  logic        ms_accept;
  logic        ms_leave;
  logic [1:0]  drop_inc;
  logic        drop_dec;
  logic [31:0] load_rdata;
  logic [31:0] load_data;

  assign es_inst = '{pc: es_pc, rf_we: es_rf_we, rf_waddr: es_rf_waddr, result: es_result,
                     res_from_mem: es_res_from_mem, ld_inst: es_ld_inst, csr_re: es_csr_re};

  // ms_valid qualifies the match so a stale ms_wait can never claim a response.
  assign data_ok_for_me = data_sram_data_ok & (drop_cnt == 2'd0) & ms_valid & ms_wait;
  assign ms_ready_go    = ~ms_wait | data_ok_for_me | buf_valid;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~wb_ex;
  assign ms_leave       = ms_to_ws_valid & ws_allowin;
  assign ms_accept      = es_to_ms_valid & ms_allowin & ~wb_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      ms_wait     <= 1'b0;
      ms_inst     <= '0;
      ms_ex_zip_r <= '0;
    end else begin
      if (wb_ex)
        ms_valid <= 1'b0;
      else if (ms_allowin)
        ms_valid <= es_to_ms_valid;
      if (ms_accept) begin
        ms_inst     <= es_inst;
        ms_ex_zip_r <= es_ex_zip;
        ms_wait     <= es_mem_issued;
      end
    end
  end

  // Hold the response when writeback cannot take it; the SRAM only drives rdata for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      data_buf  <= '0;
    end else if (wb_ex | ms_leave) begin
      buf_valid <= 1'b0;
    end else if (data_ok_for_me & ~ws_allowin) begin
      buf_valid <= 1'b1;
      data_buf  <= data_sram_rdata;
    end
  end

  // Count responses still owed to requests the flush cancelled: the resident's and one issued this cycle.
  assign drop_inc = wb_ex ? ({1'b0, ms_valid & ms_wait & ~buf_valid & ~data_sram_data_ok}
                             + {1'b0, es_mem_issued}) : 2'd0;
  assign drop_dec = data_sram_data_ok & (drop_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= 2'd0;
    else
      drop_cnt <= drop_next(drop_cnt, drop_inc, drop_dec);
  end

  assign load_rdata = buf_valid ? data_buf : data_sram_rdata;

  mem_load_align u_load_align (
    .rdata     (load_rdata),
    .offset    (ms_inst.result[1:0]),
    .ld_inst   (ms_inst.ld_inst),
    .load_data (load_data)
  );

  assign ms_pc           = ms_inst.pc;
  assign ms_rf_we        = ms_valid & ms_inst.rf_we;
  assign ms_rf_waddr     = ms_inst.rf_waddr;
  assign ms_final_result = ms_inst.res_from_mem ? load_data : ms_inst.result;
  assign ms_csr_re       = ms_inst.csr_re;
  assign ms_ex_zip       = ms_ex_zip_r;
  assign ms_ex           = ms_valid & (|ms_ex_zip_r[EX_FLAGS_W-1:0]);
  assign ms_data_pending = ms_valid & ms_inst.res_from_mem & ms_wait & ~buf_valid & ~data_ok_for_me;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed literal cases plus randomized traffic checked each cycle
// against a transaction-level model (resident instruction + in-order SRAM response queue).
module tb_mem_stage;
  localparam int ZW = 86;

  logic          clk = 1'b0;
  logic          reset;
  logic          es_to_ms_valid, ms_allowin;
  logic [31:0]   es_pc, es_result;
  logic          es_rf_we, es_res_from_mem, es_csr_re, es_mem_issued;
  logic [4:0]    es_rf_waddr, es_ld_inst;
  logic [ZW-1:0] es_ex_zip;
  logic          data_sram_data_ok;
  logic [31:0]   data_sram_rdata;
  logic          ws_allowin, ms_to_ws_valid;
  logic [31:0]   ms_pc, ms_final_result;
  logic          ms_rf_we, ms_csr_re, ms_data_pending, ms_ex, wb_ex;
  logic [4:0]    ms_rf_waddr;
  logic [ZW-1:0] ms_ex_zip;

  always #5 clk = ~clk;

  mem_stage #(.EX_ZIP_W(ZW)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_result(es_result),
    .es_res_from_mem(es_res_from_mem), .es_ld_inst(es_ld_inst), .es_csr_re(es_csr_re),
    .es_ex_zip(es_ex_zip), .es_mem_issued(es_mem_issued), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_final_result(ms_final_result),
    .ms_csr_re(ms_csr_re), .ms_ex_zip(ms_ex_zip), .ms_data_pending(ms_data_pending), .ms_ex(ms_ex),
    .wb_ex(wb_ex)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkz(input string name, input logic [ZW-1:0] act, input logic [ZW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sign/zero extension by arithmetic on shifted, masked values.
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] off,
                                          input logic [4:0] ld);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * off[1])) & 32'hFFFF;
    if (ld[4]) return (b >= 32'd128) ? b - 32'd256 : b;
    if (ld[3]) return b;
    if (ld[2]) return (h >= 32'd32768) ? h - 32'd65536 : h;
    if (ld[1]) return h;
    return d;
  endfunction

  // Outstanding SRAM requests, answered in order; cancelled ones belong to flushed instructions.
  typedef struct {
    logic [31:0] data;
    bit          cancelled;
    int          due;
  } req_t;
  req_t mq[$];
  int   cyc = 0;
  int   last_due = 0;

  // Resident instruction as the model sees it.
  bit            r_valid = 0, r_waits = 0, r_got = 0, r_rf_we = 0, r_res_mem = 0, r_csr_re = 0;
  logic [31:0]   r_pc = '0, r_result = '0, r_data = '0;
  logic [4:0]    r_waddr = '0, r_ld = '0;
  logic [ZW-1:0] r_zip = '0;

  bit          want_issue = 0;
  int          next_lat = 1;
  logic [31:0] next_data = '0;

  bit          chk_en = 0;
  bit          e_to_ws, e_allowin, e_pending, e_ex, e_rf_we, e_res_chk;
  logic [31:0] e_result;

  logic          s_to_ws, s_pending, s_ex, s_rf_we, s_dok;
  logic [31:0]   s_result;
  logic [ZW-1:0] s_zip;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("to_ws_valid", 32'(ms_to_ws_valid), 32'(e_to_ws));
      chk("allowin", 32'(ms_allowin), 32'(e_allowin));
      chk("data_pending", 32'(ms_data_pending), 32'(e_pending));
      chk("ms_ex", 32'(ms_ex), 32'(e_ex));
      chk("rf_we", 32'(ms_rf_we), 32'(e_rf_we));
      if (e_to_ws) begin
        chk("pc", ms_pc, r_pc);
        chk("rf_waddr", 32'(ms_rf_waddr), 32'(r_waddr));
        chk("csr_re", 32'(ms_csr_re), 32'(r_csr_re));
        chkz("ex_zip", ms_ex_zip, r_zip);
        if (e_res_chk) chk("final_result", ms_final_result, e_result);
      end
    end
  end

  function automatic bit has_cancel();
    foreach (mq[i]) if (mq[i].cancelled) return 1;
    return 0;
  endfunction

  task automatic set_idle();
    es_to_ms_valid = 0; want_issue = 0; wb_ex = 0; ws_allowin = 1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] res, input logic res_mem,
                           input logic [4:0] ld, input logic [ZW-1:0] zip, input int lat,
                           input logic [31:0] data);
    es_to_ms_valid = 1; es_pc = pc; es_rf_we = (zip[6:0] == 7'd0); es_rf_waddr = pc[6:2];
    es_result = res; es_res_from_mem = res_mem; es_ld_inst = ld; es_csr_re = 0; es_ex_zip = zip;
    want_issue = res_mem; next_lat = lat; next_data = data;
  endtask

  // One clock: derive expectations, let the compare process check at negedge, then advance the model.
  task automatic do_cycle();
    bit own, ready, accept;
    int due;
    req_t tmp;
    data_sram_data_ok = (mq.size() > 0) && (mq[0].due <= cyc);
    data_sram_rdata   = data_sram_data_ok ? mq[0].data : $urandom;
    own = data_sram_data_ok && !mq[0].cancelled && r_valid && r_waits && !r_got;
    ready     = !r_waits || r_got || own;
    e_to_ws   = r_valid && ready && !wb_ex;
    e_allowin = !r_valid || (ready && ws_allowin);
    e_pending = r_valid && r_res_mem && r_waits && !r_got && !own;
    e_ex      = r_valid && (r_zip[6:0] != 7'd0);
    e_rf_we   = r_valid && r_rf_we;
    e_res_chk = !(r_res_mem && !r_waits);
    e_result  = r_res_mem ? extract(own ? data_sram_rdata : r_data, r_result[1:0], r_ld) : r_result;
    accept    = es_to_ms_valid && e_allowin && !wb_ex;
    es_mem_issued = want_issue && es_to_ms_valid && (wb_ex || e_allowin);
    chk_en = 1;
    @(negedge clk);
    s_to_ws = ms_to_ws_valid; s_pending = ms_data_pending; s_ex = ms_ex; s_rf_we = ms_rf_we;
    s_result = ms_final_result; s_zip = ms_ex_zip; s_dok = data_sram_data_ok;
    @(posedge clk);
    if (data_sram_data_ok) mq.delete(0);
    if (own) begin r_got = 1; r_data = data_sram_rdata; end
    if (wb_ex) begin
      foreach (mq[i]) mq[i].cancelled = 1;
      r_valid = 0;
    end else begin
      if (e_to_ws && ws_allowin) r_valid = 0;
      if (accept) begin
        r_valid = 1; r_pc = es_pc; r_rf_we = es_rf_we; r_waddr = es_rf_waddr; r_result = es_result;
        r_res_mem = es_res_from_mem; r_ld = es_ld_inst; r_csr_re = es_csr_re; r_zip = es_ex_zip;
        r_waits = es_mem_issued; r_got = 0;
      end
    end
    if (es_mem_issued) begin
      due = (cyc + next_lat > last_due + 1) ? cyc + next_lat : last_due + 1;
      tmp.data = next_data; tmp.cancelled = wb_ex; tmp.due = due;
      mq.push_back(tmp);
      last_due = due;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    chk_en = 0; reset = 1; set_idle(); es_mem_issued = 0; data_sram_data_ok = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_to_ws", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_rf_we", 32'(ms_rf_we), 32'd0);
    chk("rst_ex", 32'(ms_ex), 32'd0);
    chk("rst_pending", 32'(ms_data_pending), 32'd0);
    chk("rst_pc", ms_pc, 32'd0);
    chk("rst_result", ms_final_result, 32'd0);
    chkz("rst_ex_zip", ms_ex_zip, '0);
    mq.delete(); r_valid = 0; last_due = cyc;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  logic [4:0]  ext_ld[4]  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010};
  logic [31:0] ext_adr[4] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002};
  logic [31:0] ext_exp[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};

  initial begin
    int pend, ign, kind;
    bit done;
    logic [ZW-1:0] zip;
    es_pc = '0; es_result = '0; es_rf_we = 0; es_rf_waddr = '0; es_res_from_mem = 0;
    es_ld_inst = '0; es_csr_re = 0; es_ex_zip = '0; es_mem_issued = 0;
    data_sram_data_ok = 0; data_sram_rdata = '0;
    set_idle();
    do_reset(2);

    // plain ALU op passes in one cycle
    set_instr(32'h100, 32'h5, 0, 5'd0, '0, 1, 32'd0);
    do_cycle(); set_idle(); do_cycle();
    chk("add_valid", 32'(s_to_ws), 32'd1);
    chk("add_result", s_result, 32'h5);
    chk("add_rf_we", 32'(s_rf_we), 32'd1);

    // ld_w with three wait cycles
    set_instr(32'h104, 32'h1000, 1, 5'b00001, '0, 4, 32'hDEADBEEF);
    do_cycle(); set_idle();
    pend = 0; done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      do_cycle();
      if (s_pending) pend++;
      if (s_to_ws) begin
        done = 1;
        chk("ldw_result", s_result, 32'hDEADBEEF);
      end
    end
    chk("ldw_done", 32'(done), 32'd1);
    chk("ldw_pending_cycles", 32'(pend), 32'd3);

    // byte/halfword extraction
    for (int k = 0; k < 4; k++) begin
      set_instr(32'h200 + 32'(4 * k), ext_adr[k], 1, ext_ld[k], '0, 1, 32'h80FF0000);
      do_cycle(); set_idle(); do_cycle();
      chk("ext_valid", 32'(s_to_ws), 32'd1);
      chk("ext_result", s_result, ext_exp[k]);
    end

    // response arrives while writeback stalls
    set_instr(32'h300, 32'h3000, 1, 5'b00001, '0, 1, 32'h12345678);
    do_cycle(); set_idle(); ws_allowin = 0;
    do_cycle(); do_cycle(); do_cycle();
    ws_allowin = 1;
    do_cycle();
    chk("buf_valid", 32'(s_to_ws), 32'd1);
    chk("buf_result", s_result, 32'h12345678);

    // flush with a waiting load and a same-cycle issue: two responses dropped
    set_instr(32'h400, 32'h4000, 1, 5'b00001, '0, 6, 32'hAAAA0001);
    do_cycle();
    set_instr(32'h404, 32'h4004, 1, 5'b00001, '0, 1, 32'hBBBB0002);
    wb_ex = 1;
    do_cycle();
    wb_ex = 0;
    set_instr(32'h408, 32'h4008, 1, 5'b00001, '0, 1, 32'hCAFEF00D);
    do_cycle(); set_idle();
    ign = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      do_cycle();
      if (s_to_ws) begin
        done = 1;
        chk("drop_result", s_result, 32'hCAFEF00D);
      end else if (s_dok) ign++;
    end
    chk("drop_done", 32'(done), 32'd1);
    chk("drop_ignored", 32'(ign), 32'd2);

    // exception instruction passes through untouched
    zip = '0; zip[1] = 1'b1; zip[85] = 1'b1; zip[20:7] = 14'h44; zip[52:21] = 32'h13579BDF;
    set_instr(32'h500, 32'h77, 0, 5'd0, zip, 1, 32'd0);
    do_cycle(); set_idle(); do_cycle();
    chk("ine_ex", 32'(s_ex), 32'd1);
    chk("ine_valid", 32'(s_to_ws), 32'd1);
    chk("ine_pending", 32'(s_pending), 32'd0);
    chkz("ine_zip", s_zip, zip);

    // reset during a wait, then normal traffic resumes
    set_instr(32'h600, 32'h5000, 1, 5'b00001, '0, 6, 32'h55);
    do_cycle(); set_idle(); do_cycle();
    do_reset(1);
    set_instr(32'h604, 32'h9, 0, 5'd0, '0, 1, 32'd0);
    do_cycle(); set_idle(); do_cycle();
    chk("post_rst_result", s_result, 32'h9);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      ws_allowin = ($urandom % 4) != 0;
      wb_ex = !has_cancel() && (($urandom % 25) == 0);
      if (($urandom % 3) != 0) begin
        kind = int'($urandom % 4);
        if (kind == 1) begin
          set_instr($urandom, $urandom, 1, 5'b00001 << ($urandom % 5), '0,
                    int'(1 + $urandom % 5), $urandom);
        end else if (kind == 2) begin
          zip = {22'($urandom), $urandom, $urandom};
          zip[6:0] = 7'b0000001 << ($urandom % 7);
          set_instr($urandom, $urandom, 0, 5'd0, zip, 1, 32'd0);
        end else begin
          set_instr($urandom, $urandom, 0, 5'd0, '0, 1, 32'd0);
          es_csr_re = (kind == 3);
        end
      end else begin
        es_to_ms_valid = 0; want_issue = 0;
      end
      do_cycle();
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and the writeback stage. Latches each instruction handed over by execute, waits for the data-SRAM `data_ok` response of any load/store that execute issued, and extracts and sign/zero-extends load data. Forwards the result and a load-pending flag to decode, and passes the exception/CSR bundle to writeback. Discards data responses belonging to requests cancelled by a writeback exception.

## Interface
Parameters:
- `EX_ZIP_W`, 86: exception/CSR bundle width, `{csr_we, csr_wmask[31:0], csr_wvalue[31:0], csr_num[13:0], ertn, has_int, adef, sys, brk, ine, ale}`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `es_to_ms_valid` in 1: execute offers an instruction.
- `ms_allowin` out 1: stage can accept this cycle.
- `es_pc` in 32; `es_rf_we` in 1; `es_rf_waddr` in 5; `es_result` in 32 (ALU/counter result, also the access address); `es_res_from_mem` in 1; `es_ld_inst` in 5 `{ld_b, ld_bu, ld_h, ld_hu, ld_w}`; `es_csr_re` in 1; `es_ex_zip` in EX_ZIP_W.
- `es_mem_issued` in 1: execute's data request handshook (`data_sram_req & data_sram_addr_ok`) this cycle.
- `data_sram_data_ok` in 1; `data_sram_rdata` in 32.
- `ws_allowin` in 1; `ms_to_ws_valid` out 1.
- `ms_pc` out 32; `ms_rf_we` out 1; `ms_rf_waddr` out 5; `ms_final_result` out 32; `ms_csr_re` out 1; `ms_ex_zip` out EX_ZIP_W.
- `ms_data_pending` out 1: resident load has no data yet (decode must stall a dependent read).
- `ms_ex` out 1: resident instruction carries an exception (execute suppresses new requests).
- `wb_ex` in 1: writeback flush (exception or ertn).

## Operation
- Accept when `es_to_ms_valid & ms_allowin`; latch all `es_*` fields plus `ms_wait = es_mem_issued`.
- `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_ready_go = !ms_wait | data_ok_for_me | buf_valid`; `data_ok_for_me = data_sram_data_ok & drop_cnt==0 & ms_wait`.
- Data buffer: if `data_ok_for_me & !ws_allowin`, store rdata in `data_buf`, set `buf_valid`; clear `buf_valid` when the instruction leaves or on `wb_ex`.
- Drop counter `drop_cnt` (2 bits, sat. max 2): on `wb_ex`, increment by (`ms_valid & ms_wait & !buf_valid & !data_sram_data_ok`) + (`es_mem_issued`). Any `data_sram_data_ok` while `drop_cnt != 0` decrements it and is ignored. Simultaneous increment and decrement net out.
- `wb_ex`: `ms_valid <= 0` next edge; no acceptance that cycle; `ms_to_ws_valid = 0`.
- Load extraction from `rd = buf_valid ? data_buf : data_sram_rdata`, offset `ms_result[1:0]`: ld_b/bu selects byte at offset, sign/zero-extend; ld_h/hu selects halfword at `offset[1]`, sign/zero-extend; ld_w passes all 32 bits.
- `ms_final_result = ms_res_from_mem ? load_data : ms_result`.
- `ms_rf_we` output = `ms_valid & ms_rf_we_reg`; `ms_ex = ms_valid & |ms_ex_zip[6:0]`; `ms_data_pending = ms_valid & ms_res_from_mem & ms_wait & !buf_valid & !data_ok_for_me`.
- Instructions with exception reach here with `ms_wait = 0` (execute never issued them) and pass through in one cycle.

## Timing
- Reset: `ms_valid`, `ms_wait`, `buf_valid`, `drop_cnt`, all latched fields = 0. Hence `ms_to_ws_valid=0`, `ms_allowin=1`, `ms_rf_we=0`, `ms_ex=0`, `ms_data_pending=0`, `ms_pc=0`, `ms_final_result=0`, `ms_ex_zip=0`.
- Non-memory instruction: resident one cycle when `ws_allowin=1`.
- Load: `ms_to_ws_valid` asserts combinationally in the `data_ok` cycle; earliest is the cycle after acceptance; zero-wait throughput one per cycle.
- Reset asserted mid-wait: all state cleared next edge, `drop_cnt` cleared (memory side is reset simultaneously).

## Structure
- Shared package: `EX_ZIP_W`, field offsets of the ex bundle, `ld_inst` bit indices, `DROP_MAX=2`.
- Sub-module `mem_load_align`: purely combinational (rdata, offset, ld_inst) -> 32-bit extended load data.

## Test plan
- ld_w at 0x1000, data_ok 3 cycles later with 0xDEADBEEF -> `ms_data_pending` high 3 cycles, then `ms_to_ws_valid=1`, result 0xDEADBEEF.
- ld_b offset 3, rdata 0x80FF_0000 -> 0xFFFFFF80; ld_bu same -> 0x00000080; ld_h offset 2 -> 0xFFFF80FF; ld_hu -> 0x000080FF.
- data_ok while `ws_allowin=0`, rdata 0x12345678 changes after -> buffered; when ws_allowin rises, forwards 0x12345678.
- Load waiting plus `wb_ex` in same cycle as execute's `es_mem_issued` -> `drop_cnt=2`; next two data_ok ignored; third data_ok completes a new load.
- add instruction with `es_result=0x5`, ws_allowin=1 -> `ms_to_ws_valid` same cycle after accept, `ms_final_result=0x5`, `ms_rf_we=1`.
- Instruction with `ine` set -> `ms_ex=1`, no wait, `ms_ex_zip` passed unchanged.
